// File: rtl/asyn_fifo_wr_arb.sv
// rtl/asyn_fifo_wr_arb.sv - burst write-port arbiter in front of an asyn_fifo write side
// Build option: define ASYN_FIFO_WR_ARB_PRIO_EN for fixed lowest-index-first priority;
// left undefined, arbitration is round-robin starting after the last granted requester.
module asyn_fifo_wr_arb #(
   parameter int D_BITS    = 8,
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 8
) (
   input  logic                      w_clk,
   input  logic                      w_rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_last,
   input  logic [N_REQ*D_BITS-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          grant,
   input  logic                      w_full,
   output logic [D_BITS-1:0]         w_data,
   output logic                      w_inc,
   output logic                      busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int BEAT_W = $clog2(MAX_BURST + 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_REQ - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [N_REQ-1:0]  grant_q;
   logic [IDX_W-1:0]  gidx_q;
   logic [IDX_W-1:0]  last_idx_q;
   logic [BEAT_W-1:0] beat_q;

   logic [IDX_W-1:0]  sel_idx;
   logic              any_valid;
   logic              xfer;
   logic              release_now;
   logic              start_grant;

   logic [D_BITS-1:0] data_arr [N_REQ];

   // Unpack the flat requester data bus so the granted word can be picked by index.
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign data_arr[gi] = req_data[gi*D_BITS +: D_BITS];
      end
   endgenerate

`ifdef ASYN_FIFO_WR_ARB_PRIO_EN
   // Fixed priority: lowest-index valid requester wins, history is irrelevant.
   function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] v,
                                             input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] r;
      logic             hit;
      logic [IDX_W-1:0] unused_last;
      unused_last = last;
      idx = '0;
      r   = '0;
      hit = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!hit && v[idx]) begin
            hit = 1'b1;
            r   = idx;
         end
         if (idx != IDX_MAX) idx = idx + 1'b1;
      end
      return r;
   endfunction
`else
   // Round-robin: scan upward starting one past the last granted index, wrapping at N_REQ.
   function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] v,
                                             input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] r;
      logic             hit;
      idx = last;
      r   = '0;
      hit = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (idx == IDX_MAX) idx = '0;
         else                idx = idx + 1'b1;
         if (!hit && v[idx]) begin
            hit = 1'b1;
            r   = idx;
         end
      end
      return r;
   endfunction
`endif

   // Arbitration decision and transfer/release qualifiers for the current cycle.
   always_comb begin
      any_valid   = |req_valid;
      sel_idx     = pick(req_valid, last_idx_q);
      start_grant = (state_q == IDLE) && any_valid;
      xfer        = (state_q == GRANT) && req_valid[gidx_q] && !w_full;
      release_now = xfer && (req_last[gidx_q] || (beat_q == BEAT_LAST));
   end

   // State register.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: enter GRANT on any request, leave on the releasing transfer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_valid)   state_d = GRANT;
         GRANT:   if (release_now) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant vector, granted index and round-robin history.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         grant_q    <= '0;
         gidx_q     <= '0;
         last_idx_q <= IDX_MAX;
      end else if (start_grant) begin
         grant_q    <= N_REQ'(1) << sel_idx;
         gidx_q     <= sel_idx;
         last_idx_q <= sel_idx;
      end else if (release_now) begin
         grant_q    <= '0;
      end
   end

   // Beat counter: cleared at grant, advanced per transfer, frozen on stalls and bubbles.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         beat_q <= '0;
      end else if (start_grant || release_now) begin
         beat_q <= '0;
      end else if (xfer) begin
         beat_q <= beat_q + 1'b1;
      end
   end

   // Outputs: handshake and write port are combinational from the registered grant.
   always_comb begin
      grant     = grant_q;
      busy      = (state_q == GRANT);
      req_ready = '0;
      w_data    = '0;
      w_inc     = xfer;
      if (state_q == GRANT) begin
         req_ready = grant_q & {N_REQ{~w_full}};
         w_data    = data_arr[gidx_q];
      end
   end

endmodule
